// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family: output mode
// encoding and a width helper for fill counters.
package seq_det_pkg;

  typedef enum logic {
    MODE_MEALY = 1'b0,
    MODE_MOORE = 1'b1
  } det_mode_e;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones until
// cleared or reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_reg;

  assign sat   = &count_reg;
  assign count = count_reg;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !sat) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector: compares the last N accepted bits of w
// against PATTERN, with Mealy/Moore output, overlap control and match counting.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             MOORE   = 0,
  parameter int             CNT_W   = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             en,
  input  logic             w,
  input  logic             overlap,
  input  logic             clear,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int             FW        = clog2(N);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N - 1);
  localparam det_mode_e      MODE      = (MOORE != 0) ? MODE_MOORE : MODE_MEALY;

  generate
    if (N < 2 || N > 32 || CNT_W < 1) begin : g_param_check
      $error("seq_pattern_detector: N must be 2..32 and CNT_W >= 1");
    end
  endgenerate

  logic [N-2:0]  hist_reg;
  logic [N-2:0]  hist_next;
  logic [FW-1:0] fill_reg;
  logic [FW-1:0] fill_next;
  logic          z_reg;
  logic [N-1:0]  window;
  logic          match;

  // Oldest bit in the MSB, the bit arriving this cycle in the LSB.
  assign window = {hist_reg, w};

  always_comb begin
    hist_next = hist_reg;
    fill_next = fill_reg;
    match     = en && !clear && (fill_reg == FILL_FULL) && (window == PATTERN);
    if (clear) begin
      hist_next = '0;
      fill_next = '0;
    end else if (en) begin
      if (match && !overlap) begin
        // Matched bits are consumed; the next match needs N fresh bits.
        hist_next = '0;
        fill_next = '0;
      end else begin
        hist_next = window[N-2:0];
        if (fill_reg != FILL_FULL) begin
          fill_next = fill_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hist_reg <= '0;
      fill_reg <= '0;
      z_reg    <= 1'b0;
    end else begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      z_reg    <= match;
    end
  end

  assign z = (MODE == MODE_MOORE) ? z_reg : match;

  sat_counter #(
    .W(CNT_W)
  ) u_match_counter (
    .Clock (Clock),
    .Resetn(Resetn),
    .clr   (clear),
    .inc   (match),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: four detector configurations share one stimulus bus;
// expected outputs go through scoreboard queues and are popped at sampling.
module tb_seq_pattern_detector;

  logic       Clock;
  logic       Resetn;
  logic       en;
  logic       w;
  logic       overlap;
  logic       clear;

  logic       z_m, sat_m;
  logic [7:0] cnt_m;
  logic       z_o, sat_o;
  logic [7:0] cnt_o;
  logic       z_s, sat_s;
  logic [1:0] cnt_s;
  logic       z_l, sat_l;
  logic [7:0] cnt_l;

  int errors = 0;
  int checks = 0;

  bit q_z[$];
  bit q_zo[$];

  seq_pattern_detector u_mealy (
    .Clock(Clock), .Resetn(Resetn), .en(en), .w(w), .overlap(overlap), .clear(clear),
    .z(z_m), .match_count(cnt_m), .count_sat(sat_m)
  );

  seq_pattern_detector #(.MOORE(1)) u_moore (
    .Clock(Clock), .Resetn(Resetn), .en(en), .w(w), .overlap(overlap), .clear(clear),
    .z(z_o), .match_count(cnt_o), .count_sat(sat_o)
  );

  seq_pattern_detector #(.CNT_W(2)) u_sat (
    .Clock(Clock), .Resetn(Resetn), .en(en), .w(w), .overlap(overlap), .clear(clear),
    .z(z_s), .match_count(cnt_s), .count_sat(sat_s)
  );

  seq_pattern_detector #(.N(2), .PATTERN(2'b11)) u_legacy (
    .Clock(Clock), .Resetn(Resetn), .en(en), .w(w), .overlap(overlap), .clear(clear),
    .z(z_l), .match_count(cnt_l), .count_sat(sat_l)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Inputs change on the falling edge; Mealy z is sampled 2 time units later.
  task automatic drive(input logic e, input logic b, input logic c);
    @(negedge Clock);
    en    = e;
    w     = b;
    clear = c;
    #2;
  endtask

  task automatic finish_cycle;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_clear;
    drive(1'b1, 1'b1, 1'b1);
    finish_cycle();
  endtask

  task automatic test_reset;
    bit pre[7] = '{1, 0, 1, 1, 1, 0, 1};
    bit post[4] = '{1, 0, 1, 1};
    bit exp_post[4] = '{0, 0, 0, 1};
    bit e;
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, pre[i], 1'b0);
      finish_cycle();
    end
    drive(1'b1, 1'b1, 1'b0);
    Resetn = 1'b0;
    #1;
    checks++;
    if (z_m !== 1'b0) begin errors++; $display("FAIL reset_z_mealy: got %b want 0", z_m); end
    checks++;
    if (z_o !== 1'b0) begin errors++; $display("FAIL reset_z_moore: got %b want 0", z_o); end
    checks++;
    if (cnt_m !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt_m); end
    checks++;
    if (sat_m !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat_m); end
    finish_cycle();
    finish_cycle();
    checks++;
    if (z_m !== 1'b0 || cnt_m !== 8'd0) begin
      errors++;
      $display("FAIL reset_hold: got z=%b count=%0d want z=0 count=0", z_m, cnt_m);
    end
    @(negedge Clock);
    en = 1'b0;
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_z.push_back(exp_post[i]);
      drive(1'b1, post[i], 1'b0);
      e = q_z.pop_front();
      checks++;
      if (z_m !== e) begin errors++; $display("FAIL post_reset_z[%0d]: got %b want %b", i, z_m, e); end
      finish_cycle();
    end
    checks++;
    if (cnt_m !== 8'd1) begin errors++; $display("FAIL post_reset_count: got %0d want 1", cnt_m); end
  endtask

  task automatic test_overlap;
    bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit exp_z[7]  = '{0, 0, 0, 1, 0, 0, 1};
    bit e;
    int exp_cnt;
    overlap = 1'b1;
    do_clear();
    checks++;
    if (cnt_m !== 8'd0 || z_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: got count=%0d zq=%b want 0 0", cnt_m, z_o);
    end
    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      q_z.push_back(exp_z[i]);
      q_zo.push_back(exp_z[i]);
      drive(1'b1, stream[i], 1'b0);
      e = q_z.pop_front();
      checks++;
      if (z_m !== e) begin errors++; $display("FAIL ovl_mealy_z cycle %0d: got %b want %b", i + 1, z_m, e); end
      finish_cycle();
      exp_cnt += int'(exp_z[i]);
      e = q_zo.pop_front();
      checks++;
      if (z_o !== e) begin errors++; $display("FAIL ovl_moore_z cycle %0d: got %b want %b", i + 2, z_o, e); end
      checks++;
      if (cnt_m !== 8'(exp_cnt) || cnt_o !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL ovl_count cycle %0d: got mealy=%0d moore=%0d want %0d", i + 1, cnt_m, cnt_o, exp_cnt);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    finish_cycle();
    checks++;
    if (z_o !== 1'b0) begin errors++; $display("FAIL moore_pulse_width: got %b want 0", z_o); end
  endtask

  task automatic test_no_overlap;
    bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit exp_z[7]  = '{0, 0, 0, 1, 0, 0, 0};
    bit e;
    overlap = 1'b0;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      q_z.push_back(exp_z[i]);
      drive(1'b1, stream[i], 1'b0);
      e = q_z.pop_front();
      checks++;
      if (z_m !== e) begin errors++; $display("FAIL novl_z cycle %0d: got %b want %b", i + 1, z_m, e); end
      finish_cycle();
    end
    checks++;
    if (cnt_m !== 8'd1) begin errors++; $display("FAIL novl_count: got %0d want 1", cnt_m); end
  endtask

  task automatic test_hold_clear;
    bit first[3] = '{1, 0, 1};
    bit hold_w[3] = '{1, 0, 1};
    bit again[4] = '{1, 0, 1, 1};
    bit exp_again[4] = '{0, 0, 0, 1};
    bit e;
    overlap = 1'b1;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, first[i], 1'b0);
      finish_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      q_z.push_back(1'b0);
      drive(1'b0, hold_w[i], 1'b0);
      e = q_z.pop_front();
      checks++;
      if (z_m !== e) begin errors++; $display("FAIL hold_z[%0d]: got %b want %b", i, z_m, e); end
      finish_cycle();
    end
    q_z.push_back(1'b1);
    drive(1'b1, 1'b1, 1'b0);
    e = q_z.pop_front();
    checks++;
    if (z_m !== e) begin errors++; $display("FAIL hold_match_z: got %b want %b", z_m, e); end
    finish_cycle();
    checks++;
    if (cnt_m !== 8'd1) begin errors++; $display("FAIL hold_count: got %0d want 1", cnt_m); end
    do_clear();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, first[i], 1'b0);
      finish_cycle();
    end
    q_z.push_back(1'b0);
    drive(1'b1, 1'b1, 1'b1);
    e = q_z.pop_front();
    checks++;
    if (z_m !== e) begin errors++; $display("FAIL clear_suppress_z: got %b want %b", z_m, e); end
    finish_cycle();
    checks++;
    if (cnt_m !== 8'd0 || z_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_suppress_count: got count=%0d moore_z=%b want 0 0", cnt_m, z_o);
    end
    for (int i = 0; i < 4; i++) begin
      q_z.push_back(exp_again[i]);
      drive(1'b1, again[i], 1'b0);
      e = q_z.pop_front();
      checks++;
      if (z_m !== e) begin errors++; $display("FAIL after_clear_z[%0d]: got %b want %b", i, z_m, e); end
      finish_cycle();
    end
  endtask

  task automatic test_saturation;
    bit b;
    bit e;
    bit exp_m;
    int exp_cnt;
    int pulses;
    overlap = 1'b1;
    do_clear();
    exp_cnt = 0;
    pulses  = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) b = (i != 1);
      else       b = ((i - 4) % 3 != 0);
      exp_m = (i >= 3) && ((i - 3) % 3 == 0);
      q_z.push_back(exp_m);
      drive(1'b1, b, 1'b0);
      e = q_z.pop_front();
      checks++;
      if (z_s !== e) begin errors++; $display("FAIL sat_z bit %0d: got %b want %b", i + 1, z_s, e); end
      if (z_s === 1'b1) pulses++;
      finish_cycle();
      if (exp_m && exp_cnt != 3) exp_cnt++;
      checks++;
      if (cnt_s !== 2'(exp_cnt) || sat_s !== (exp_cnt == 3)) begin
        errors++;
        $display("FAIL sat_count bit %0d: got count=%0d sat=%b want count=%0d sat=%b",
                 i + 1, cnt_s, sat_s, exp_cnt, (exp_cnt == 3));
      end
    end
    checks++;
    if (pulses != 5) begin errors++; $display("FAIL sat_pulses: got %0d want 5", pulses); end
  endtask

  task automatic test_legacy;
    bit prev;
    bit b;
    bit e;
    int exp_cnt;
    int fails;
    overlap = 1'b1;
    do_clear();
    prev    = 1'b0;
    exp_cnt = 0;
    fails   = 0;
    for (int i = 0; i < 1000; i++) begin
      b = 1'($urandom_range(0, 1));
      q_z.push_back(prev & b);
      drive(1'b1, b, 1'b0);
      e = q_z.pop_front();
      checks++;
      if (z_l !== e) begin
        errors++;
        fails++;
        if (fails <= 10) $display("FAIL legacy_z bit %0d: got %b want %b", i, z_l, e);
      end
      finish_cycle();
      if (e && exp_cnt != 255) exp_cnt++;
      prev = b;
    end
    checks++;
    if (cnt_l !== 8'(exp_cnt)) begin errors++; $display("FAIL legacy_count: got %0d want %0d", cnt_l, exp_cnt); end
  endtask

  initial begin
    Resetn  = 1'b0;
    en      = 1'b0;
    w       = 1'b0;
    overlap = 1'b1;
    clear   = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_hold_clear();
    test_saturation();
    test_legacy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
